mux_rr_arbiter: RTL and testbench

Round-robin arbiter and output stage for the shared 4-to-1 data mux. Four requesters each present a DW-bit word with a valid/ready handshake. The block grants one requester at a time for a burst of up to BURST beats and drives the mux select. Each accepted beat passes through a single registered output slot with valid/ready backpressure. It sits between the four requesters and the downstream consumer of the mux output.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/mux_rr_arbiter_rr_pick.sv | 33 +++
 rtl/mux_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 4-to-1 round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, bit i = requester i
//   ptr     : first index to consider; scan order ptr, ptr+1, ... mod 4
//   grant   : index of the first requesting bit in scan order
//   any_req : at least one request bit set
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   grant,
    output logic               any_req
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // First set bit at or after ptr; the SEL_W-bit add wraps mod 4.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx     = '0;
        any_req = |req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = SEL_W'(ptr + SEL_W'(i));
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and registered output slot for the shared 4:1 data mux.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid     : per-requester valid
//   a, b, c, d    : data words of requesters 0..3
//   req_ready     : per-requester ready (combinational, at most one bit high)
//   out_valid     : output slot holds a beat
//   out_data      : beat in the output slot
//   out_sel       : requester that produced out_data
//   out_ready     : consumer accepts when out_valid && out_ready
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW    = 4,
    parameter int unsigned BURST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [DW-1:0]      a,
    input  logic [DW-1:0]      b,
    input  logic [DW-1:0]      c,
    input  logic [DW-1:0]      d,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] g_q, g_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             out_valid_d;
    logic [DW-1:0]    out_data_d;
    logic [SEL_W-1:0] out_sel_d;
    logic [SEL_W-1:0] pick;
    logic             any_req;
    logic             slot_free;
    logic             xfer;
    logic [DW-1:0]    sel_word;

    rr_pick u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

    // 4:1 datapath mux indexed by the current grant.
    always_comb begin
        case (g_q)
            2'd0:    sel_word = a;
            2'd1:    sel_word = b;
            2'd2:    sel_word = c;
            default: sel_word = d;
        endcase
    end

    assign slot_free = !out_valid || out_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Next-state, ready and output-slot logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        xfer        = 1'b0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_sel_d   = out_sel;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d     = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ready[g_q] = slot_free;
                if (!req_valid[g_q]) begin
                    // Requester released the grant without a transfer.
                    state_d = IDLE;
                    ptr_d   = SEL_W'(g_q + SEL_W'(1));
                end else if (slot_free) begin
                    xfer  = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST)) begin
                        state_d = IDLE;
                        ptr_d   = SEL_W'(g_q + SEL_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat takes priority over draining the slot.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
            out_sel_d   = g_q;
        end else if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_sel   <= out_sel_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: two arbiters (BURST=1 and BURST=3) share one stimulus;
// a per-instance transaction-level model predicts outputs every cycle.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] a = '0, b = '0, c = '0, d = '0;
    logic       out_ready = 1'b1;

    logic [3:0] rdy [2];
    logic       ov  [2];
    logic [3:0] od  [2];
    logic [1:0] os  [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DW(4), .BURST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .a(a), .b(b), .c(c), .d(d),
        .req_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_sel(os[0]), .out_ready(out_ready)
    );

    mux_rr_arbiter #(.DW(4), .BURST(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .a(a), .b(b), .c(c), .d(d),
        .req_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_sel(os[1]), .out_ready(out_ready)
    );

    // Model: busy = a grant is held, left = beats remaining in it.
    typedef struct {
        bit         busy;
        int         g;
        int         left;
        int         ptr;
        bit         ov;
        logic [3:0] od;
        int         os;
    } mstate_t;

    typedef struct {
        int sel;
        int data;
        int cyc;
    } beat_t;

    mstate_t m [2];
    beat_t   lg0 [$];
    beat_t   lg1 [$];
    int      bursts [2] = '{1, 3};

    function automatic mstate_t mzero();
        mstate_t s;
        s.busy = 0; s.g = 0; s.left = 0; s.ptr = 0;
        s.ov = 0; s.od = '0; s.os = 0;
        return s;
    endfunction

    function automatic mstate_t step(mstate_t s, int burst, logic [3:0] rv,
                                     logic ordy, logic [15:0] wv);
        mstate_t n = s;
        bit found = 0;
        bit xf = 0;
        if (!s.busy) begin
            for (int i = 0; i < 4; i++) begin
                int j = (s.ptr + i) % 4;
                if (!found && rv[j]) begin
                    found = 1; n.busy = 1; n.g = j; n.left = burst;
                end
            end
        end else if (!rv[s.g]) begin
            n.busy = 0; n.ptr = (s.g + 1) % 4;
        end else if (!s.ov || ordy) begin
            xf = 1;
        end
        if (xf) begin
            n.ov = 1; n.od = wv[s.g*4 +: 4]; n.os = s.g;
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.busy = 0; n.ptr = (s.g + 1) % 4;
            end
        end else if (s.ov && ordy) begin
            n.ov = 0;
        end
        return n;
    endfunction

    function automatic logic [3:0] mready(mstate_t s, logic ordy);
        logic [3:0] r = '0;
        if (s.busy && (!s.ov || ordy)) r[s.g] = 1'b1;
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    // Model update.
    initial begin
        m[0] = mzero();
        m[1] = mzero();
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) m[k] = mzero();
                else m[k] = step(m[k], bursts[k], req_valid, out_ready, {d, c, b, a});
            end
        end
    end

    // Cycle counter and accepted-beat log.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (ov[0] && out_ready) lg0.push_back('{int'(os[0]), int'(od[0]), cyc});
                if (ov[1] && out_ready) lg1.push_back('{int'(os[1]), int'(od[1]), cyc});
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.out_valid", k), int'(ov[k]), int'(m[k].ov));
                chk($sformatf("u%0d.out_data", k), int'(od[k]), int'(m[k].od));
                chk($sformatf("u%0d.out_sel", k), int'(os[k]), m[k].os);
                chk($sformatf("u%0d.req_ready", k), int'(rdy[k]), int'(mready(m[k], out_ready)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        req_valid = '0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lg0.delete();
        lg1.delete();
    endtask

    task automatic wait_log(int k, int n, int budget, string nm);
        int t = 0;
        while (((k == 0) ? lg0.size() : lg1.size()) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) timeout(nm);
    endtask

    initial begin
        int t0;
        int n;
        int bud;
        int exp_sel1 [5] = '{0, 1, 2, 3, 0};
        int exp_dat1 [5] = '{1, 2, 3, 4, 1};
        int exp_dat2 [4] = '{5, 6, 7, 8};
        int exp_cyc2 [4] = '{2, 3, 4, 6};
        int exp_sel4 [3] = '{2, 3, 0};

        // Reset state.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset out_valid", int'(ov[k]), 0);
            chk("reset req_ready", int'(rdy[k]), 0);
            chk("reset out_sel", int'(os[k]), 0);
            chk("reset out_data", int'(od[k]), 0);
        end
        do_reset();

        // 1: all requesting, BURST=1 rotates 0,1,2,3,0, one beat per 2 cycles.
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        req_valid = 4'b1111;
        t0 = cyc;
        wait_log(0, 5, 40, "t1 beats");
        if (lg0.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t1 sel[%0d]", i), lg0[i].sel, exp_sel1[i]);
                chk($sformatf("t1 data[%0d]", i), lg0[i].data, exp_dat1[i]);
            end
            chk("t1 first beat latency", lg0[0].cyc - t0, 2);
            for (int i = 0; i < 4; i++)
                chk($sformatf("t1 spacing[%0d]", i), lg0[i+1].cyc - lg0[i].cyc, 2);
        end
        do_reset();

        // 2: BURST=3, requester 2 streams 5,6,7,8: three beats, bubble, one beat.
        c = 4'd5;
        req_valid = 4'b0100;
        t0 = cyc;
        n = 0;
        bud = 0;
        while (n < 4 && bud < 40) begin
            @(negedge clk);
            bud++;
            if (rdy[1][2]) begin
                @(posedge clk);
                #1;
                n++;
                c = 4'(5 + n);
            end
        end
        if (n < 4) timeout("t2 stream");
        req_valid = '0;
        wait_log(1, 4, 20, "t2 beats");
        if (lg1.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2 sel[%0d]", i), lg1[i].sel, 2);
                chk($sformatf("t2 data[%0d]", i), lg1[i].data, exp_dat2[i]);
                chk($sformatf("t2 cycle[%0d]", i), lg1[i].cyc - t0, exp_cyc2[i]);
            end
        end
        do_reset();

        // 3: backpressure for 4 cycles after the first beat holds 4'h9.
        a = 4'h9;
        req_valid = 4'b0001;
        bud = 0;
        while (!ov[1] && bud < 20) begin
            @(negedge clk);
            bud++;
        end
        if (!ov[1]) timeout("t3 first beat");
        #1;
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3 hold out_valid", int'(ov[1]), 1);
            chk("t3 hold out_data", int'(od[1]), 9);
            chk("t3 hold req_ready", int'(rdy[1]), 0);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3 resume out_valid", int'(ov[1]), 1);
        chk("t3 resume beats", lg1.size(), 1);
        do_reset();

        // 4: requester 1 releases before transferring; next grants 2, 3, then 0.
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = 4'b1101;
        wait_log(0, 3, 40, "t4 beats");
        if (lg0.size() >= 3) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("t4 sel[%0d]", i), lg0[i].sel, exp_sel4[i]);
        end
        wait_log(1, 1, 20, "t4 u3 beat");
        if (lg1.size() >= 1) chk("t4 u3 first sel", lg1[0].sel, 2);
        do_reset();

        // 5: asynchronous reset mid-burst, then requester 3 is granted first.
        a = 4'd5;
        req_valid = 4'b0001;
        bud = 0;
        while (!ov[1] && bud < 20) begin
            @(negedge clk);
            bud++;
        end
        if (!ov[1]) timeout("t5 first beat");
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5 async out_valid", int'(ov[k]), 0);
            chk("t5 async req_ready", int'(rdy[k]), 0);
            chk("t5 async out_sel", int'(os[k]), 0);
        end
        req_valid = 4'b1000;
        d = 4'hd;
        @(negedge clk);
        #1;
        lg0.delete();
        lg1.delete();
        rst_n = 1'b1;
        wait_log(0, 1, 20, "t5 u1 beat");
        wait_log(1, 1, 20, "t5 u3 beat");
        if (lg0.size() >= 1) begin
            chk("t5 u1 sel", lg0[0].sel, 3);
            chk("t5 u1 data", lg0[0].data, 13);
        end
        if (lg1.size() >= 1) chk("t5 u3 sel", lg1[0].sel, 3);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
